// File: rtl/synth_pkg.sv
// Shared definitions for the voice sequencer: default sizing, voice record
// field widths and the scheduler FSM encoding.
package synth_pkg;

    localparam int unsigned NVOICES_DEF     = 16;
    localparam int unsigned PHASE_W_DEF     = 20;
    localparam int unsigned SLOT_CYCLES_DEF = 4;

    localparam int unsigned VOICE_W  = 4;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned VEL_W    = 18;
    localparam int unsigned ACTIVE_W = 1;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StIssue,
        StHold
    } sched_state_e;

endpackage

// File: rtl/phase_acc_bank.sv
// Per-voice phase accumulators. A note-on clear beats a same-cycle slot advance,
// so a retriggered voice always restarts from phase 0.
module phase_acc_bank
    import synth_pkg::*;
#(
    parameter int unsigned NVOICES = NVOICES_DEF,
    parameter int unsigned PHASE_W = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_en,
    input  logic [VOICE_W-1:0] clr_idx,
    input  logic               adv_en,
    input  logic [VOICE_W-1:0] adv_idx,
    input  logic [PHASE_W-1:0] adv_inc,
    input  logic [VOICE_W-1:0] rd_idx,
    output logic [PHASE_W-1:0] rd_phase
);

    logic [PHASE_W-1:0] phase_q [NVOICES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NVOICES; v++) begin
                phase_q[v] <= '0;
            end
        end else begin
            for (int v = 0; v < NVOICES; v++) begin
                if (clr_en && (clr_idx == VOICE_W'(v))) begin
                    phase_q[v] <= '0;
                end else if (adv_en && (adv_idx == VOICE_W'(v))) begin
                    phase_q[v] <= phase_q[v] + adv_inc;
                end
            end
        end
    end

    assign rd_phase = phase_q[rd_idx];

endmodule

// File: rtl/voice_scheduler.sv
// Per-frame voice walker: on each 48 kHz tick, issues one right/left wavetable
// slot per active voice and advances that voice's phase.
module voice_scheduler
    import synth_pkg::*;
#(
    parameter int unsigned        NVOICES     = NVOICES_DEF,
    parameter int unsigned        PHASE_W     = PHASE_W_DEF,
    parameter int unsigned        SLOT_CYCLES = SLOT_CYCLES_DEF,
    parameter logic [ADDR_W-1:0]  L_OFFSET    = 10'd0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick48k,
    input  logic               cfg_we,
    input  logic [VOICE_W-1:0] cfg_voice,
    input  logic               cfg_on,
    input  logic               cfg_off,
    input  logic [PHASE_W-1:0] cfg_inc,
    input  logic [VEL_W-1:0]   cfg_vel,
    output logic [ADDR_W-1:0]  wavetable_r,
    output logic               wavetable_r_valid,
    output logic [ADDR_W-1:0]  wavetable_l,
    output logic               wavetable_l_valid,
    output logic [VEL_W-1:0]   velocity,
    output logic [VOICE_W-1:0] voice_id,
    output logic               busy,
    output logic               overrun
);

    localparam int unsigned HOLD_W = $clog2(SLOT_CYCLES);

    sched_state_e        state_q, state_d;
    logic [VOICE_W-1:0]  idx_q, idx_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                busy_q, busy_d;
    logic                overrun_q, overrun_d;

    logic [NVOICES-1:0]  active_q;
    logic [PHASE_W-1:0]  inc_q [NVOICES];
    logic [VEL_W-1:0]    vel_q [NVOICES];

    logic                r_valid_q, l_valid_q;
    logic [ADDR_W-1:0]   addr_r_q, addr_l_q;
    logic [VEL_W-1:0]    vel_out_q;
    logic [VOICE_W-1:0]  id_q;

    logic                load_slot, adv_en, last_idx, cfg_hit;
    logic                cur_active;
    logic [PHASE_W-1:0]  rd_phase, cur_phase;
    logic [VEL_W-1:0]    cur_vel;
    logic [ADDR_W-1:0]   cur_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= '0;
            for (int v = 0; v < NVOICES; v++) begin
                inc_q[v] <= '0;
                vel_q[v] <= '0;
            end
        end else if (cfg_we) begin
            if (cfg_on) begin
                active_q[cfg_voice] <= 1'b1;
                inc_q[cfg_voice]    <= cfg_inc;
                vel_q[cfg_voice]    <= cfg_vel;
            end else if (cfg_off) begin
                active_q[cfg_voice] <= 1'b0;
            end
        end
    end

    phase_acc_bank #(
        .NVOICES (NVOICES),
        .PHASE_W (PHASE_W)
    ) u_phase_acc_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_en   (cfg_we && cfg_on),
        .clr_idx  (cfg_voice),
        .adv_en   (adv_en),
        .adv_idx  (idx_q),
        .adv_inc  (inc_q[idx_q]),
        .rd_idx   (idx_q),
        .rd_phase (rd_phase)
    );

    // Forward a same-cycle config write so a note-on at the scanned index plays now.
    always_comb begin
        cfg_hit    = cfg_we && (cfg_voice == idx_q);
        cur_active = active_q[idx_q];
        cur_phase  = rd_phase;
        cur_vel    = vel_q[idx_q];
        if (cfg_hit && cfg_on) begin
            cur_active = 1'b1;
            cur_phase  = '0;
            cur_vel    = cfg_vel;
        end else if (cfg_hit && cfg_off) begin
            cur_active = 1'b0;
        end
        cur_addr = cur_phase[PHASE_W-1 -: ADDR_W];
    end

    assign last_idx = (idx_q == VOICE_W'(NVOICES - 1));

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        busy_d    = busy_q;
        overrun_d = overrun_q | (tick48k & busy_q);
        load_slot = 1'b0;
        adv_en    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (tick48k) begin
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StScan;
                end
            end
            StScan: begin
                if (cur_active) begin
                    load_slot = 1'b1;
                    state_d   = StIssue;
                end else if (last_idx) begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StIssue: begin
                adv_en  = 1'b1;
                hold_d  = '0;
                state_d = StHold;
            end
            StHold: begin
                if (hold_q == HOLD_W'(SLOT_CYCLES - 2)) begin
                    if (last_idx) begin
                        busy_d  = 1'b0;
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StScan;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            r_valid_q <= 1'b0;
            l_valid_q <= 1'b0;
            addr_r_q  <= '0;
            addr_l_q  <= '0;
            vel_out_q <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            r_valid_q <= load_slot;
            l_valid_q <= (state_q == StIssue);
            if (load_slot) begin
                addr_r_q  <= cur_addr;
                addr_l_q  <= cur_addr + L_OFFSET;
                vel_out_q <= cur_vel;
                id_q      <= idx_q;
            end
        end
    end

    assign wavetable_r       = addr_r_q;
    assign wavetable_r_valid = r_valid_q;
    assign wavetable_l       = addr_l_q;
    assign wavetable_l_valid = l_valid_q;
    assign velocity          = vel_out_q;
    assign voice_id          = id_q;
    assign busy              = busy_q;
    assign overrun           = overrun_q;

endmodule
